// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA timing sequencer (640x480@60 defaults).
package vga_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Sync pulses sit right after the front porch; end positions are inclusive.
    localparam int unsigned HS_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
    localparam int unsigned HS_END_DEF   = HS_START_DEF + H_SYNC_DEF - 1;
    localparam int unsigned VS_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
    localparam int unsigned VS_END_DEF   = VS_START_DEF + V_SYNC_DEF - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } vga_state_e;

    // Drive level of a sync line given whether the pulse is active.
    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_timing_ctrl_pixel_tick_gen.sv
// Divide-by-2 pixel enable: toggles every clk_50 cycle, 0 in reset.
module pixel_tick_gen (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    logic tick_q;

    // Free-running toggle; first high cycle is the one right after reset release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) tick_q <= 1'b0;
        else         tick_q <= ~tick_q;
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing sequencer: counters, start/stop FSM and sync/blank decode.
//
// state | meaning
// IDLE  | display stopped, counters parked at (0,0), syncs inactive
// RUN   | scanning, frame wraps to (0,0) with a frame_start pulse
// DRAIN | stop requested, finishing the current frame before IDLE
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       en,
    output logic       pix_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       frame_start,
    output logic       busy
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
        $error("vga_timing_ctrl: H_TOTAL/V_TOTAL must fit 10-bit counters");
    end

    vga_state_e state_q, state_d;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic [9:0] x_inc, y_inc;
    logic       frame_end;
    logic       running_d;
    logic       hsync_q, hsync_d, vsync_q, vsync_d;
    logic       video_q, video_d;
    logic       fs_q, fs_d;
    logic       busy_q;
    logic       tick;

    pixel_tick_gen u_tick (
        .clk_i  (clk_50),
        .rst_ni (rst_n),
        .tick_o (tick)
    );

    // Next state, next counters, and decode of the outputs from the next position.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        fs_d      = 1'b0;
        frame_end = (x_q == H_LAST) && (y_q == V_LAST);
        x_inc     = (x_q == H_LAST) ? 10'd0 : x_q + 10'd1;
        y_inc     = y_q;
        if (x_q == H_LAST) y_inc = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;

        case (state_q)
            IDLE: begin
                x_d = 10'd0;
                y_d = 10'd0;
                if (en) begin
                    state_d = RUN;
                    fs_d    = 1'b1;
                end
            end
            RUN: begin
                x_d = x_inc;
                y_d = y_inc;
                if (!en) state_d = frame_end ? IDLE : DRAIN;
                else     fs_d    = frame_end;
            end
            DRAIN: begin
                x_d = x_inc;
                y_d = y_inc;
                if (en) begin
                    state_d = RUN;
                    fs_d    = frame_end;
                end else if (frame_end) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                x_d     = 10'd0;
                y_d     = 10'd0;
            end
        endcase

        running_d = (state_d != IDLE);
        hsync_d   = sync_level(running_d && x_d >= HS_START && x_d <= HS_END, SYNC_POL);
        vsync_d   = sync_level(running_d && y_d >= VS_START && y_d <= VS_END, SYNC_POL);
        video_d   = running_d && (x_d < H_ACT) && (y_d < V_ACT);
    end

    // State and output registers advance on pixel ticks; frame_start lasts one clk_50.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= 10'd0;
            y_q     <= 10'd0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            video_q <= 1'b0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else if (tick) begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            video_q <= video_d;
            fs_q    <= fs_d;
            busy_q  <= running_d;
        end else begin
            fs_q    <= 1'b0;
        end
    end

    assign pix_tick    = tick;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_q;
    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign frame_start = fs_q;
    assign busy        = busy_q;

endmodule
